palette_ram_ctrl: RTL
=====================

# palette_ram_ctrl

Writable 256-entry RGB332 colour-lookup controller between the pixel-index scanout path and the VGA colour output. After reset it copies the fixed default palette ROM into an internal 256x8 RAM, one entry per clock. It then serves one scanout lookup per clock and accepts single-entry host rewrites, with a req/ack handshake, on cycles the scanout does not use the RAM. A host command reloads the ROM defaults at any time.

## Interface
Parameters:
- BLANK_RGB, 8'h00, value driven on out_rgb during INIT.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- rom_index  out  8  address to the combinational default palette ROM
- rom_rgb  in  8  ROM data for rom_index, valid in the same cycle
- init_done  out  1  high when state is RUN
- pix_valid  in  1  scanout lookup request this cycle
- pix_index  in  8  palette index to look up
- out_valid  out  1  pix_valid delayed 1 cycle
- out_rgb  out  8  looked-up RGB332 colour
- host_wr_req  in  1  host write request; held until ack
- host_wr_index  in  8  entry to write; stable while req is high
- host_wr_rgb  in  8  colour to write; stable while req is high
- host_wr_ack  out  1  one-cycle pulse; write has been committed
- host_reload  in  1  one-cycle pulse; restart ROM copy

## Operation
- States: INIT, RUN. An 8-bit counter cnt is used in INIT.
- rst: state=INIT, cnt=0, out_valid=0, out_rgb=BLANK_RGB, host_wr_ack=0, init_done=0. RAM contents are not cleared; INIT overwrites them.
- INIT: rom_index=cnt. Each cycle, mem[cnt]<=rom_rgb and cnt<=cnt+1.
  - At cnt==255 the write happens, cnt wraps to 0 and state goes to RUN.
  - INIT lasts exactly 256 cycles.
- RUN: rom_index=0.
- Scanout, every cycle in either state: out_valid<=pix_valid.
  - In RUN with pix_valid=1: out_rgb<=mem[pix_index].
  - In INIT: out_rgb<=BLANK_RGB.
  - In RUN with pix_valid=0: out_rgb holds its value.
- Host write grant: grant = (state==RUN) & host_wr_req & ~pix_valid & ~host_wr_ack & ~host_reload.
  - On grant: mem[host_wr_index]<=host_wr_rgb and host_wr_ack<=1 for the next cycle.
  - The ack-gap term stops a held request being written twice. The host must drop req, or present new data, in the ack cycle.
- Arbitration: scanout always wins. A host request waits, unbounded, until a cycle with pix_valid=0. Blanking intervals guarantee progress.
- Reload: host_reload=1 in RUN sets state<=INIT and cnt<=0 on the next edge, with no grant that cycle. host_reload in INIT is ignored; the copy does not restart.
- Host requests pending during INIT are neither acked nor lost. They are granted once RUN is reached.
- Single-port RAM semantics: at most one RAM write or read per cycle, and reads and writes never collide by construction.

## Timing
- Lookup latency 1: pix_valid/pix_index sampled at edge N gives out_valid/out_rgb at N+1. Back-to-back lookups run at full rate.
- Write-to-read: a host write committed at edge N is visible to a lookup sampled at edge N+1 or later.
- Ack: host_wr_ack rises at the edge following grant and lasts exactly 1 cycle. Minimum spacing between two acks is 2 cycles.
- init_done rises on the same edge that loads entry 255: 256 cycles after rst deasserts, or after a host_reload is accepted.
- Reset mid-INIT or mid-RUN: the next edge gives the reset values above and restarts the copy from entry 0. A pending host write is dropped unacked, and the host must re-request.

## Test plan
- Reset/copy: deassert rst with a ROM model, check rom_index steps 0..255 over 256 cycles, then init_done=1. Lookup 8'h07 -> 8'hDB, 8'hF9 -> 8'hE0, 8'hFF -> 8'hFF.
- Scanout stream: pix_valid=1 with index 0,1,2,3 on consecutive cycles -> out_rgb 00,80,10,90 one cycle later each; out_valid mirrors pix_valid delayed by 1.
- Host write under contention: req index 8'h05 rgb 8'h3C with pix_valid=1 for 10 cycles -> no ack. Drop pix_valid -> ack 1 cycle later, and a lookup of 05 returns 3C.
- Held request: keep req high for 6 idle cycles with the same data -> acks at cycles 2,4,6 only. RAM holds the same value, and there are no back-to-back acks.
- Reload: overwrite entry 00 with FF, pulse host_reload -> init_done=0 for 256 cycles, out_rgb=BLANK_RGB during that time, then entry 00 reads 00 again. A second host_reload mid-INIT does not extend INIT.
- Reset mid-INIT at cnt=100 -> cnt restarts at 0; init_done rises 256 cycles after rst drops; pending host req not acked before then.

Source files
------------

// File: rtl/palette_ram_ctrl.sv
// -----------------------------------------------------------------------------
// palette_ram_ctrl
//
// Writable 256-entry RGB332 colour-lookup controller sitting between the
// pixel-index scanout path and the VGA colour output.
//
// After reset (and after a host reload) the controller walks the external
// combinational default-palette ROM and copies it into an internal 256x8 RAM,
// one entry per clock (state INIT, 256 cycles). In RUN it serves one scanout
// lookup per clock with a latency of one cycle, and commits single-entry host
// rewrites on cycles the scanout leaves the RAM idle.
//
// Ports
//   clk           in   system clock, all state updates on the rising edge
//   rst           in   synchronous active-high reset
//   rom_index     out  address into the default palette ROM (cnt in INIT, 0 in RUN)
//   rom_rgb       in   ROM data for rom_index, valid in the same cycle
//   init_done     out  high while the controller is in RUN
//   pix_valid     in   scanout lookup request this cycle
//   pix_index     in   palette index to look up
//   out_valid     out  pix_valid delayed by one cycle
//   out_rgb       out  looked-up colour (BLANK_RGB while INIT)
//   host_wr_req   in   host write request, held until acknowledged
//   host_wr_index in   entry to write, stable while the request is high
//   host_wr_rgb   in   colour to write, stable while the request is high
//   host_wr_ack   out  one-cycle pulse, the write has been committed
//   host_reload   in   one-cycle pulse, restart the ROM copy (ignored in INIT)
//
// Parameters
//   BLANK_RGB     colour driven on out_rgb while the copy is in progress
// -----------------------------------------------------------------------------
module palette_ram_ctrl #(
    parameter logic [7:0] BLANK_RGB = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] rom_index,
    input  logic [7:0] rom_rgb,
    output logic       init_done,
    input  logic       pix_valid,
    input  logic [7:0] pix_index,
    output logic       out_valid,
    output logic [7:0] out_rgb,
    input  logic       host_wr_req,
    input  logic [7:0] host_wr_index,
    input  logic [7:0] host_wr_rgb,
    output logic       host_wr_ack,
    input  logic       host_reload
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Declarations
    // -------------------------------------------------------------------------
    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_next;

    logic       r_out_valid;
    logic [7:0] r_out_rgb;
    logic       r_ack;

    logic [7:0] r_mem [0:255];

    // Decoded FSM outputs
    logic       w_in_run;
    logic       w_copy_we;
    logic [7:0] w_rom_index;

    // RAM port arbitration
    logic       w_grant;
    logic       w_mem_we;
    logic [7:0] w_mem_waddr;
    logic [7:0] w_mem_wdata;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_INIT;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_INIT: begin
                // The counter wraps 255 -> 0 on the last copy edge, so it is
                // already zero when RUN is entered. A reload here is ignored
                // on purpose: the copy in progress is never restarted.
                w_cnt_next = r_cnt + 8'd1;
                if (r_cnt == 8'hFF) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (host_reload) begin
                    w_state_next = ST_INIT;
                    w_cnt_next   = 8'd0;
                end
            end
            default: begin
                w_state_next = ST_INIT;
                w_cnt_next   = 8'd0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: output decode
    // -------------------------------------------------------------------------
    always_comb begin
        w_in_run    = 1'b0;
        w_copy_we   = 1'b0;
        w_rom_index = 8'd0;
        case (r_state)
            ST_INIT: begin
                w_copy_we   = 1'b1;
                w_rom_index = r_cnt;
            end
            ST_RUN: begin
                w_in_run = 1'b1;
            end
            default: begin
                w_in_run = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // RAM port arbitration
    //
    // Scanout always owns the RAM when pix_valid is high. A host write is only
    // granted on an idle RUN cycle. The r_ack term leaves a dead cycle after
    // every commit so a request still held high during its ack cycle is not
    // written a second time; a reload cycle is kept free of grants because the
    // copy starts overwriting the RAM on the very next edge.
    // -------------------------------------------------------------------------
    assign w_grant = w_in_run & host_wr_req & ~pix_valid & ~r_ack & ~host_reload;

    // Only one writer can be active: copy happens in INIT, grant only in RUN.
    // Writes are suppressed on a reset edge so a dropped request leaves no trace.
    assign w_mem_we    = ~rst & (w_copy_we | w_grant);
    assign w_mem_waddr = w_copy_we ? r_cnt   : host_wr_index;
    assign w_mem_wdata = w_copy_we ? rom_rgb : host_wr_rgb;

    // -------------------------------------------------------------------------
    // Palette RAM: write port (contents are not reset; INIT overwrites them)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    // -------------------------------------------------------------------------
    // Palette RAM: registered read port, doubling as the colour output
    // register. It is enabled only by a RUN lookup and otherwise holds, so the
    // last colour stays on out_rgb across idle cycles. During INIT it is forced
    // to the blanking colour.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_rgb <= BLANK_RGB;
        end else if (!w_in_run) begin
            r_out_rgb <= BLANK_RGB;
        end else if (pix_valid) begin
            r_out_rgb <= r_mem[pix_index];
        end
    end

    // -------------------------------------------------------------------------
    // Handshake and valid pipeline
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_ack       <= 1'b0;
        end else begin
            r_out_valid <= pix_valid;
            r_ack       <= w_grant;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign rom_index   = w_rom_index;
    assign init_done   = w_in_run;
    assign out_valid   = r_out_valid;
    assign out_rgb     = r_out_rgb;
    assign host_wr_ack = r_ack;

endmodule
